afpm_io_sequencer: RTL and testbench
====================================

# afpm_io_sequencer

Byte-level I/O framing stage for the logarithmic FP16 multiplier. It collects the two 16-bit half-precision operands from the 8-bit `ui_in` (A) and `uio_in` (B) pins, low byte first, and issues them to the multiplier core with a valid strobe. It then captures the 16-bit product and streams it out on `uo_out`, low byte first. It sits between the top-level pins and the multiplier core, and it owns all sequencing and the core-stall timeout.

## Interface
- `TIMEOUT`, 15: WAIT cycles without `res_valid` before a forced NaN result (1..255).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: design enable; when low, every register holds its value.
- `ui_in` in 8: operand A byte.
- `uio_in` in 8: operand B byte.
- `uo_out` out 8: result byte, registered.
- `op_a` out 16: assembled operand A to the core, registered.
- `op_b` out 16: assembled operand B to the core, registered.
- `op_valid` out 1: one-cycle issue strobe to the core.
- `res` in 16: product from the core.
- `res_valid` in 1: product valid from the core.
- `frame_sync` out 1: high during LOAD_LO; marks the first cycle of a frame.
- `err` out 1: sticky flag, set when any timeout has occurred.

## Operation
- States: LOAD_LO, LOAD_HI, ISSUE, WAIT, OUT_LO, OUT_HI. The state after reset is LOAD_LO.
- **LOAD_LO:** `op_a[7:0]` ← `ui_in` and `op_b[7:0]` ← `uio_in`. Next state is LOAD_HI.
- **LOAD_HI:** `op_a[15:8]` ← `ui_in` and `op_b[15:8]` ← `uio_in`. Next state is ISSUE.
- **ISSUE:** `op_valid` = 1 for exactly this cycle. If `res_valid` = 1 in the same cycle, capture `res` and go to OUT_LO. Otherwise go to WAIT and clear the wait counter.
- **WAIT:** if `res_valid` = 1, capture `res` and go to OUT_LO.
  - Otherwise, if the counter equals `TIMEOUT`-1, the captured result becomes 16'h7E00 (FP16 qNaN), `err` is set, and the next state is OUT_LO.
  - Otherwise the counter increments.
- **OUT_LO:** `uo_out` shows `res_q[7:0]`. Next state is OUT_HI.
- **OUT_HI:** `uo_out` shows `res_q[15:8]`. Next state is LOAD_LO.
- `uo_out` holds its last value in all other states. The block does not zero it between frames.
- `res_valid` is ignored in LOAD_LO, LOAD_HI, OUT_LO and OUT_HI. No result is queued, and no error is raised for it.
- `op_a` and `op_b` stay stable from the end of LOAD_HI until the next LOAD_LO/LOAD_HI writes.
- **`ena` low:** the FSM, counter and all outputs freeze. `op_valid` is forced to 0 while `ena` is low and the state is re-entered when `ena` returns high, so the issue strobe is never duplicated.
- **Reset values** (`rst_n` low at a rising edge, in any state, mid-frame included):
  - `uo_out`, `op_a`, `op_b` and `res_q` = 0.
  - `op_valid` = 0, `err` = 0, wait counter = 0.
  - State = LOAD_LO; `frame_sync` = 1 on the first cycle after release.
- Widths: the wait counter is `$clog2(TIMEOUT+1)` bits. No arithmetic is performed on the data.

## Timing
- Frame length with a same-cycle core (`res_valid` in ISSUE) is 5 cycles: LOAD_LO, LOAD_HI, ISSUE, OUT_LO, OUT_HI.
- Frame length with a core of latency L ≥ 1 is 5+L cycles.
- Frame length on timeout is 5+`TIMEOUT` cycles.
- `op_valid` is asserted in cycle 2 of the frame (LOAD_LO = cycle 0).
- The low result byte is visible on `uo_out` in the cycle after the result is captured; the high byte follows one cycle later.
- `frame_sync` is decoded combinationally from the state register.
- Frames repeat back-to-back with no idle cycle.

## Structure
- Package `afpm_pkg`:
  - `afpm_state_t` enum for the six states.
  - `FP16_QNAN` = 16'h7E00.
  - `FP16_W` = 16 and `BYTE_W` = 8.
- One sub-module, `afpm_wait_timer`, holds the parameterised timeout counter. Its ports are clear, count-enable and an expired flag.
- The FSM, the operand registers and the output mux live in `afpm_io_sequencer`.

## Test plan
- **Reset mid-frame:** assert `rst_n`=0 during WAIT → next cycle the state is LOAD_LO, `uo_out`=0, `op_valid`=0, `err`=0, `frame_sync`=1.
- **Same-cycle core:** A=16'h43BC, B=16'h4190, bytes BC/90 then 43/41; the stub returns `res`=16'h48F4 with `res_valid` in ISSUE → `op_a`=43BC, `op_b`=4190, `op_valid` high one cycle, `uo_out`=F4 then 48, next frame starts at cycle 5.
- **Latency-3 core:** same operands → `uo_out`=F4 in frame cycle 6, 48 in cycle 7, `err`=0.
- **Stalled core** (no `res_valid`, `TIMEOUT`=15) → `uo_out`=00 then 7E, `err`=1 and it stays 1 through later good frames.
- **Spurious `res_valid`:** pulse `res_valid` in LOAD_HI and OUT_HI → no state change and `uo_out` unaffected.
- **`ena` toggling:** drop `ena` during ISSUE for 3 cycles → exactly one `op_valid` pulse, and the frame completes with the correct bytes.

Source files
------------

// File: rtl/afpm_pkg.sv
// Shared types and constants for the FP16 multiplier byte-I/O sequencer.
package afpm_pkg;

    localparam int FP16_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        LOAD_LO = 3'd0,
        LOAD_HI = 3'd1,
        ISSUE   = 3'd2,
        WAIT    = 3'd3,
        OUT_LO  = 3'd4,
        OUT_HI  = 3'd5
    } afpm_state_t;

endpackage

// File: rtl/afpm_wait_timer.sv
// Core-stall timer: counts WAIT cycles and flags the last cycle before timeout.
module afpm_wait_timer
    import afpm_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Wait counter: cleared on entry to WAIT, frozen while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (ena) begin
            if (i_clear) begin
                r_count <= '0;
            end else if (i_count_en) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/afpm_io_sequencer.sv
// Byte-serial operand collection, core issue and result streaming for the
// logarithmic FP16 multiplier.
module afpm_io_sequencer
    import afpm_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [BYTE_W-1:0] ui_in,
    input  logic [BYTE_W-1:0] uio_in,
    output logic [BYTE_W-1:0] uo_out,
    output logic [FP16_W-1:0] op_a,
    output logic [FP16_W-1:0] op_b,
    output logic              op_valid,
    input  logic [FP16_W-1:0] res,
    input  logic              res_valid,
    output logic              frame_sync,
    output logic              err
);

    afpm_state_t       r_state;
    afpm_state_t       w_next_state;
    logic [FP16_W-1:0] r_op_a;
    logic [FP16_W-1:0] r_op_b;
    logic [FP16_W-1:0] r_res_q;
    logic [BYTE_W-1:0] r_uo_out;
    logic              r_err;

    logic              w_capture;
    logic [FP16_W-1:0] w_cap_data;
    logic              w_timeout;
    logic              w_clear;
    logic              w_count_en;
    logic              w_expired;

    afpm_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .i_clear    (w_clear),
        .i_count_en (w_count_en),
        .o_expired  (w_expired)
    );

    // Next-state and capture decode; res_valid only matters in ISSUE and WAIT.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_cap_data   = res;
        w_timeout    = 1'b0;
        w_clear      = 1'b0;
        w_count_en   = 1'b0;
        case (r_state)
            LOAD_LO: w_next_state = LOAD_HI;
            LOAD_HI: w_next_state = ISSUE;
            ISSUE: begin
                if (res_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = OUT_LO;
                end else begin
                    w_clear      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = OUT_LO;
                end else if (w_expired) begin
                    w_capture    = 1'b1;
                    w_cap_data   = FP16_QNAN;
                    w_timeout    = 1'b1;
                    w_next_state = OUT_LO;
                end else begin
                    w_count_en   = 1'b1;
                end
            end
            OUT_LO:  w_next_state = OUT_HI;
            OUT_HI:  w_next_state = LOAD_LO;
            default: w_next_state = LOAD_LO;
        endcase
    end

    // State, operand, result and output registers; everything holds while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= LOAD_LO;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_res_q  <= '0;
            r_uo_out <= '0;
            r_err    <= 1'b0;
        end else if (ena) begin
            r_state <= w_next_state;
            case (r_state)
                LOAD_LO: begin
                    r_op_a[BYTE_W-1:0] <= ui_in;
                    r_op_b[BYTE_W-1:0] <= uio_in;
                end
                LOAD_HI: begin
                    r_op_a[FP16_W-1:BYTE_W] <= ui_in;
                    r_op_b[FP16_W-1:BYTE_W] <= uio_in;
                end
                default: begin
                    r_op_a <= r_op_a;
                    r_op_b <= r_op_b;
                end
            endcase
            // Low byte is loaded together with the capture so it shows during OUT_LO.
            if (w_capture) begin
                r_res_q  <= w_cap_data;
                r_uo_out <= w_cap_data[BYTE_W-1:0];
            end else if (r_state == OUT_LO) begin
                r_uo_out <= r_res_q[FP16_W-1:BYTE_W];
            end else begin
                r_uo_out <= r_uo_out;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end else begin
            r_state <= r_state;
        end
    end

    assign op_valid   = (r_state == ISSUE) && ena;
    assign frame_sync = (r_state == LOAD_LO);
    assign uo_out     = r_uo_out;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign err        = r_err;

endmodule

// File: tb/tb_afpm_io_sequencer.sv
// Scoreboard bench for afpm_io_sequencer: stimulus queues per-frame expectations,
// a negedge monitor closes each frame on frame_sync and compares.
module tb_afpm_io_sequencer;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [7:0]  ui_in;
    logic [7:0]  uio_in;
    logic [7:0]  uo_out;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic [15:0] res;
    logic        res_valid;
    logic        frame_sync;
    logic        err;

    afpm_io_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uo_out     (uo_out),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .res        (res),
        .res_valid  (res_valid),
        .frame_sync (frame_sync),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          len;
        logic        err;
        bit          aborted;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;
    logic rst_d;

    always @(posedge clk) rst_d <= rst_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: samples on the falling edge, counts ena-high cycles per frame.
    initial begin : monitor
        bit         started;
        int         cyc;
        int         pulses;
        logic [7:0] h1;
        logic [7:0] h2;
        exp_t       e;
        started = 1'b0;
        cyc = 0;
        pulses = 0;
        h1 = 8'h00;
        h2 = 8'h00;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("queue_drained", exp_q.size(), 0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
            if (rst_d === 1'b0) begin
                chk("rst_uo_out", uo_out, 8'h00);
                chk("rst_op_a", op_a, 16'h0000);
                chk("rst_op_b", op_b, 16'h0000);
                chk("rst_op_valid", op_valid, 1'b0);
                chk("rst_err", err, 1'b0);
                chk("rst_frame_sync", frame_sync, 1'b1);
                while (exp_q.size() > 0 && exp_q[0].aborted) void'(exp_q.pop_front());
                started = 1'b0;
                cyc = 0;
                pulses = 0;
            end
            if (rst_n === 1'b1 && ena === 1'b1) begin
                if (frame_sync === 1'b1) begin
                    if (started) begin
                        if (exp_q.size() == 0) begin
                            chk("frame_without_expectation", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("uo_out_lo", h2, e.lo);
                            chk("uo_out_hi", h1, e.hi);
                            chk("frame_len", cyc, e.len);
                            chk("op_valid_pulses", pulses, 1);
                            chk("err_flag", err, e.err);
                        end
                    end
                    started = 1'b1;
                    cyc = 0;
                    pulses = 0;
                end
                cyc++;
                if (op_valid === 1'b1) begin
                    pulses++;
                    if (exp_q.size() > 0) begin
                        chk("op_a", op_a, exp_q[0].a);
                        chk("op_b", op_b, exp_q[0].b);
                    end else begin
                        chk("op_valid_without_expectation", 1, 0);
                    end
                end
                h2 = h1;
                h1 = uo_out;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat: 0 same-cycle, >0 core latency, <0 stalled core.
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                             input int lat, input bit spur, input int gap, input logic exp_err);
        exp_t e;
        e.a = a;
        e.b = b;
        e.lo = (lat < 0) ? 8'h00 : r[7:0];
        e.hi = (lat < 0) ? 8'h7E : r[15:8];
        e.len = (lat < 0) ? 5 + TIMEOUT : 5 + lat;
        e.err = exp_err;
        e.aborted = 1'b0;
        exp_q.push_back(e);
        ui_in = a[7:0];  uio_in = b[7:0];  res_valid = 1'b0; res = 16'h0000;
        tick();
        ui_in = a[15:8]; uio_in = b[15:8]; res_valid = spur; res = 16'hDEAD;
        tick();
        ui_in = 8'hA5; uio_in = 8'h5A; res_valid = 1'b0; res = 16'h0000;
        if (gap > 0) begin
            ena = 1'b0;
            repeat (gap) tick();
            ena = 1'b1;
        end
        if (lat == 0) begin
            res_valid = 1'b1; res = r;
            tick();
        end else begin
            tick();
            if (lat > 0) begin
                repeat (lat - 1) tick();
                res_valid = 1'b1; res = r;
                tick();
            end else begin
                repeat (TIMEOUT) tick();
            end
        end
        res_valid = 1'b0; res = 16'h0000;
        tick();
        res_valid = spur; res = 16'hDEAD;
        tick();
        res_valid = 1'b0; res = 16'h0000;
    endtask

    task automatic reset_mid_frame(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.a = a; e.b = b; e.lo = 8'h00; e.hi = 8'h00; e.len = 0; e.err = 1'b0;
        e.aborted = 1'b1;
        exp_q.push_back(e);
        ui_in = a[7:0];  uio_in = b[7:0];
        tick();
        ui_in = a[15:8]; uio_in = b[15:8];
        tick();
        res_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        res = 16'h0000; res_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run_frame(16'h43BC, 16'h4190, 16'h48F4, 0,  1'b0, 0, 1'b0);
        run_frame(16'h43BC, 16'h4190, 16'h48F4, 3,  1'b0, 0, 1'b0);
        run_frame(16'h3C00, 16'h4000, 16'h4000, -1, 1'b0, 0, 1'b1);
        run_frame(16'h1234, 16'hABCD, 16'hC3A5, 1,  1'b0, 0, 1'b1);
        run_frame(16'h43BC, 16'h4190, 16'h48F4, 0,  1'b1, 0, 1'b1);
        run_frame(16'h5A5A, 16'h0F0F, 16'h9E21, 0,  1'b0, 3, 1'b1);
        reset_mid_frame(16'h7777, 16'h8888);
        run_frame(16'hBEEF, 16'h00FF, 16'h6C18, 2,  1'b0, 0, 1'b0);
        tick();
        tick();
        done = 1'b1;
    end

endmodule
